order_entry_scheduler: RTL
==========================

Name: order_entry_scheduler

Overview:
- Shares the single matching-engine order input between N_REQ trader ports.
- Each cycle, issues at most one buy and one sell to the engine's buy_price/sell_price inputs, using two independent round-robin arbiters.
- Drives empty-slot sentinels (buy 8'h00, sell 8'hFF) when a side has no grant.
- Sequences a start/run/flush lifecycle, so the engine's 8-deep queues are drained before the scheduler idles.

Parameters:
- N_REQ, 4, number of requester ports (2..8).
- PRICE_W, 8, price width; must match the engine.
- FLUSH_CYCLES, 8, sentinel cycles issued in FLUSH; equals the engine queue depth.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; IDLE->RUN.
- stop  in  1  pulse; RUN->FLUSH.
- req_valid  in  N_REQ  per-port order valid.
- req_side  in  N_REQ  per-port side; 0=buy, 1=sell.
- req_price  in  N_REQ*PRICE_W  per-port price; port i at [i*PRICE_W +: PRICE_W].
- req_ready  out  N_REQ  per-port grant; combinational.
- match_signal  in  1  engine match flag; used only with the optional feature.
- buy_price  out  PRICE_W  to engine, registered.
- sell_price  out  PRICE_W  to engine, registered.
- busy  out  1  state != IDLE.
- flushing  out  1  state == FLUSH.
- trade_count  out  16  saturating match count; present only with the optional feature.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values:
  - state=IDLE; both RR pointers=0; flush counter=0.
  - buy_price=8'h00; sell_price=8'hFF; busy=0; flushing=0; trade_count=0.
- States: IDLE, RUN, FLUSH (2-bit encoding).
- IDLE:
  - req_ready=0; sentinels driven.
  - start=1 moves to RUN, unless stop is also 1: stop wins, stay IDLE.
- RUN:
  - Buy arbiter considers ports with req_valid&~req_side; sell arbiter considers req_valid&req_side.
  - Each grants the first eligible port at or after its pointer, in ascending index order with wrap.
  - req_ready[i]=1 for each granted port; at most 2 ports are ready per cycle.
  - Transfer = req_valid[i]&req_ready[i]. Next cycle, buy_price/sell_price = the granted port's price; a side with no grant gets its sentinel.
  - Latency: 1 clock from handshake to engine input.
  - On a grant to port g, that side's pointer becomes (g+1) mod N_REQ. With no grant, the pointer holds.
  - A stalled requester holds valid, side and price stable until ready. Dropping valid without a handshake is allowed (no order issued).
  - Prices 8'h00 (buy) and 8'hFF (sell) are passed through unchanged; the engine treats them as empty.
  - stop=1 moves to FLUSH; start is ignored. Grants in the same cycle as stop are still honoured.
- FLUSH:
  - req_ready=0; sentinels driven for exactly FLUSH_CYCLES cycles (counter 0..FLUSH_CYCLES-1).
  - Then IDLE; the counter clears.
  - start and stop are ignored.
  - Pointers are retained across FLUSH/IDLE; only reset clears them.
- Reset mid-RUN or mid-FLUSH returns everything to reset values immediately; no partial flush.

Optional Feature:
- Macro: ORDER_SCHED_TRADE_CNT_EN.
- Defined:
  - trade_count increments by 1 on each cycle where match_signal=1 and state != IDLE.
  - Saturates at 16'hFFFF; cleared by reset and on the IDLE->RUN transition.
- Undefined: no trade_count port and no counter logic; match_signal is unused.

Decomposition:
- Package order_sched_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2).
  - PRICE_W default.
  - BUY_EMPTY=8'h00, SELL_EMPTY=8'hFF.
  - FLUSH_CYCLES default 8.
- Sub-module rr_arbiter (N-bit request in, one-hot grant and index out, internal pointer, advance on grant). Instantiated twice, buy and sell.
- The top level holds the FSM, output registers, flush counter and optional counter.

Test Plan:
- Reset then IDLE with all 4 ports valid: req_ready=0, buy_price=8'h00, sell_price=8'hFF, busy=0.
- start; port0 buy 8'd100, port1 sell 8'd98 held valid: ready=4'b0011 same cycle; next cycle buy_price=100, sell_price=98.
- RUN, all 4 ports buy, valid continuously: grants rotate 0,1,2,3,0; sell_price stays 8'hFF throughout.
- Port2 buy 50 and port3 buy 60 valid, pointer=3: port3 granted first, then port2.
- stop in RUN: flushing=1 for exactly 8 cycles with sentinels and req_ready=0; then busy=0. A start pulse during the flush is ignored.
- Reset asserted mid-FLUSH at cycle 3: state=IDLE, outputs at sentinels, pointers 0. With ORDER_SCHED_TRADE_CNT_EN, 3 match pulses in RUN give trade_count=3, and reset clears it to 0.

Source files
------------

// File: rtl/order_sched_pkg.sv
// Shared types and constants for the order entry scheduler.
package order_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int unsigned PRICE_W_DEF      = 8;
    localparam int unsigned FLUSH_CYCLES_DEF = 8;

    // Prices the matching engine treats as an empty slot.
    localparam logic [7:0] BUY_EMPTY  = 8'h00;
    localparam logic [7:0] SELL_EMPTY = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// ascending with wrap; the pointer moves past the winner on each grant.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [IDX_W-1:0] ptr_q;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] nxt;

    // Rotate requests so the pointer sits at bit 0, then take the lowest set bit.
    always_comb begin
        rot   = N'({req, req} >> ptr_q);
        off   = '0;
        any_c = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any_c = 1'b1;
                off   = IDX_W'(k);
            end
        end
        sum = SUM_W'(ptr_q) + SUM_W'(off);
        if (sum >= SUM_W'(N)) begin
            sum = sum - SUM_W'(N);
        end
        idx_c   = IDX_W'(sum);
        grant_c = any_c ? (N'(1) << idx_c) : '0;
        nxt     = SUM_W'(idx_c) + SUM_W'(1);
        if (nxt >= SUM_W'(N)) begin
            nxt = '0;
        end
    end

    // Pointer advances past the granted port; holds when nothing is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (any_c) begin
            ptr_q <= IDX_W'(nxt);
        end
    end

endmodule

// File: rtl/order_entry_scheduler.sv
// Order entry scheduler: shares the matching-engine buy/sell inputs between
// N_REQ trader ports with independent round-robin arbitration per side, and
// runs an IDLE/RUN/FLUSH lifecycle that drains the engine queues with
// empty-slot sentinels before going idle.
// Optional: define ORDER_SCHED_TRADE_CNT_EN to add the saturating trade_count.
module order_entry_scheduler
    import order_sched_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned PRICE_W      = PRICE_W_DEF,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_side,
    input  logic [N_REQ*PRICE_W-1:0] req_price,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     match_signal,
    output logic [PRICE_W-1:0]       buy_price,
    output logic [PRICE_W-1:0]       sell_price,
    output logic                     busy,
    output logic                     flushing
`ifdef ORDER_SCHED_TRADE_CNT_EN
    ,
    output logic [15:0]              trade_count
`endif
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               run;
    logic [N_REQ-1:0]   buy_req, sell_req, buy_gnt, sell_gnt;
    logic [IDX_W-1:0]   buy_idx, sell_idx;
    logic               buy_any, sell_any;
    logic [PRICE_W-1:0] price_arr [N_REQ];
    logic [PRICE_W-1:0] buy_d, sell_d;

    // Only RUN presents requests to the arbiters, so ready is low elsewhere.
    assign run       = (state_q == RUN);
    assign buy_req   = {N_REQ{run}} & req_valid & ~req_side;
    assign sell_req  = {N_REQ{run}} & req_valid & req_side;
    assign req_ready = buy_gnt | sell_gnt;

    rr_arbiter #(.N(N_REQ)) u_buy_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (buy_req),
        .grant_c (buy_gnt),
        .idx_c   (buy_idx),
        .any_c   (buy_any)
    );

    rr_arbiter #(.N(N_REQ)) u_sell_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (sell_req),
        .grant_c (sell_gnt),
        .idx_c   (sell_idx),
        .any_c   (sell_any)
    );

    // Unpack the flat price bus into per-port entries.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            price_arr[i] = req_price[i*PRICE_W +: PRICE_W];
        end
    end

    // Next-state, flush counter and next engine prices.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = '0;
        buy_d       = PRICE_W'(BUY_EMPTY);
        sell_d      = PRICE_W'(SELL_EMPTY);
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (buy_any) begin
                    buy_d = price_arr[buy_idx];
                end
                if (sell_any) begin
                    sell_d = price_arr[sell_idx];
                end
                if (stop) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered engine/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            buy_price   <= PRICE_W'(BUY_EMPTY);
            sell_price  <= PRICE_W'(SELL_EMPTY);
            busy        <= 1'b0;
            flushing    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            buy_price   <= buy_d;
            sell_price  <= sell_d;
            busy        <= (state_d != IDLE);
            flushing    <= (state_d == FLUSH);
        end
    end

`ifdef ORDER_SCHED_TRADE_CNT_EN
    // Saturating count of engine matches while active; restarts on each run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trade_count <= '0;
        end else if (state_q == IDLE && state_d == RUN) begin
            trade_count <= '0;
        end else if (match_signal && state_q != IDLE && trade_count != 16'hFFFF) begin
            trade_count <= trade_count + 16'd1;
        end
    end
`else
    logic unused_match;
    assign unused_match = match_signal;
`endif

endmodule
